store_buffer: RTL and testbench
===============================

# store_buffer

Write-side counterpart of the load byte-extender on the data-memory path. Accepts store requests from the MEM stage (sw/sh/sb), checks alignment, and converts each into a word-aligned address, a lane-replicated write word and a 4-bit byte enable. Legal stores are held in a 2-entry FIFO and drained to the data-memory write port over a valid/ready handshake. Misaligned or illegal stores are consumed, never written, and reported as an error pulse with the faulting address latched.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; fixed at 2, and the pointer/count widths below assume it.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  MEM stage presents a store.
- req_ready  output  1  buffer can accept; equals (count != 2).
- req_addr  input  32  byte address.
- req_data  input  32  store data; low byte/half used for sb/sh.
- req_op  input  2  00 sw, 01 sh, 10 sb, 11 reserved (illegal).
- m_valid  output  1  head entry valid toward memory; equals (count != 0).
- m_ready  input  1  memory accepts the head entry this cycle.
- m_addr  output  32  {head_addr[31:2], 2'b00}.
- m_wdata  output  32  lane-replicated write data.
- m_byteen  output  4  byte enables; bit i is byte lane i (bits [8i+7:8i]).
- pending  output  2  entries held (0..2).
- err  output  1  one-cycle pulse for a rejected store.
- err_addr  output  32  req_addr of the most recent rejected store.

## Operation
- Accept: req_valid && req_ready. A request without an accept is ignored; the MEM stage holds its inputs until ready.
- Alignment check on acceptance. Let A = req_addr[1:0].
  - sw is legal only if A == 00.
  - sh is legal only if A[0] == 0.
  - sb is always legal.
  - op 11 is always illegal.
- Legal-store encoding, computed on acceptance and stored in the entry:
  - sw: byteen 1111, wdata = req_data.
  - sh: byteen 0011 if A[1] == 0, else 1100; wdata = {2{req_data[15:0]}}.
  - sb: byteen = 0001 << A; wdata = {4{req_data[7:0]}}.
- Each entry stores addr[31:2], wdata and byteen.
- Illegal store: the handshake still completes; nothing is enqueued and count is unchanged. On the next cycle err=1 for exactly one cycle and err_addr = req_addr. err_addr holds until the next rejection.
- Drain: on m_valid && m_ready, the head is popped and the read pointer advances, wrapping modulo 2. Entries leave in acceptance order.
- While m_valid=0, m_addr, m_wdata and m_byteen are all 0.
- count update on the same clock edge:
  - push and no pop: count+1.
  - pop and no push: count-1.
  - push and pop together (possible only at count 1): count stays 1; the new entry is written to the tail slot while the head is popped.
- At count 2, req_ready=0 even when m_ready=1 in that cycle. There is no combinational ready-through path.
- Reset values: count, both pointers, pending, m_valid, m_addr, m_wdata, m_byteen, err and err_addr are all 0. Entry storage contents are don't-care.
- Reset asserted mid-drain: all queued stores are discarded and no further m_valid is raised. A handshake coinciding with a reset cycle has no effect.

## Timing
- Latency is 1 cycle: a store accepted at edge N appears on m_* after edge N, provided the FIFO was empty.
- m_valid, m_addr, m_wdata and m_byteen are registered-state driven (from pointer and storage). They depend only on state, never combinationally on req_*.
- req_ready depends only on count.
- Throughput: 1 store per cycle in steady state with m_ready held at 1 (count alternates 0→1 and stays at 1).
- Once m_valid=1, m_addr, m_wdata and m_byteen stay stable until the pop. Enqueuing behind the head never alters the head entry.
- The err pulse is registered and asserts in the cycle after the rejecting handshake. Back-to-back rejections keep err high, and err_addr updates each cycle.

## Test plan
- sb sweep: sb at 0x100..0x103 with data 0x000000A5, m_ready=1 → each cycle m_addr=0x100, m_wdata=0xA5A5A5A5, m_byteen 0001, 0010, 0100, 1000 in order; pending never exceeds 1.
- sh/sw encoding: sh 0x1002 with data 0x1234BEEF → m_byteen=1100, m_wdata=0xBEEFBEEF; then sw 0x2000 with data 0xDEADBEEF → byteen=1111, m_wdata=0xDEADBEEF.
- Backpressure/full: m_ready=0, push three stores on consecutive cycles → first two accepted, pending=2, req_ready=0 on the third; then release m_ready → stores drain in FIFO order with m_* stable while held.
- Simultaneous push/pop at count 1 → pending stays 1, and the second store follows the first with no bubble.
- Misaligned: sw at 0x1001, sh at 0x1003, op 11 at 0x1000 → each is accepted; err pulses the following cycle with err_addr 0x1001, 0x1003, 0x1000; pending=0; m_valid never rises.
- Reset: with 2 stores queued, assert reset for 1 cycle → next cycle pending=0, m_valid=0, err=0, err_addr=0, req_ready=1.

Source files
------------

// File: rtl/store_buffer.sv
// Store path to data memory: aligns sw/sh/sb requests into word address, lane-replicated
// data and byte enables, queues legal stores in a 2-entry FIFO, flags misaligned ones.
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_op,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  output logic [1:0]  pending,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [29:0] addr_mem   [DEPTH];
  logic [31:0] wdata_mem  [DEPTH];
  logic [3:0]  byteen_mem [DEPTH];

  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  logic        accept, push, pop, legal;
  logic [3:0]  enc_be;
  logic [31:0] enc_wd;
  logic [1:0]  a;

  assign a         = req_addr[1:0];
  assign req_ready = (count_q != FULL);
  assign m_valid   = (count_q != 2'd0);
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal;
  assign pop       = m_valid && m_ready;
  assign pending   = count_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

  always_comb begin
    legal  = 1'b0;
    enc_be = '0;
    enc_wd = '0;
    case (req_op)
      2'b00: begin
        legal  = (a == 2'b00);
        enc_be = 4'b1111;
        enc_wd = req_data;
      end
      2'b01: begin
        legal  = ~a[0];
        enc_be = a[1] ? 4'b1100 : 4'b0011;
        enc_wd = {2{req_data[15:0]}};
      end
      2'b10: begin
        legal  = 1'b1;
        enc_be = 4'b0001 << a;
        enc_wd = {4{req_data[7:0]}};
      end
      default: legal = 1'b0;
    endcase
  end

  // Head outputs are forced to zero when empty so stale storage never leaks out.
  always_comb begin
    m_addr   = '0;
    m_wdata  = '0;
    m_byteen = '0;
    if (m_valid) begin
      m_addr   = {addr_mem[rd_ptr_q], 2'b00};
      m_wdata  = wdata_mem[rd_ptr_q];
      m_byteen = byteen_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_mem[wr_ptr_q]   <= req_addr[31:2];
      wdata_mem[wr_ptr_q]  <= enc_wd;
      byteen_mem[wr_ptr_q] <= enc_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
      err_q <= accept && !legal;
      if (accept && !legal) err_addr_q <= req_addr;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: encoding, FIFO order, backpressure,
// misalignment errors and reset behaviour.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic [1:0]  pending;
  logic        err;
  logic [31:0] err_addr;

  int unsigned passed = 0;
  int unsigned total  = 0;

  store_buffer #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .pending(pending), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ad, input logic [31:0] d,
                       input logic [1:0] op);
    req_valid = v;
    req_addr  = ad;
    req_data  = d;
    req_op    = op;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick(); tick();
    reset = 1'b0;
    total++; if (pending !== 2'd0) $display("FAIL reset_pending got=%0d exp=0", pending); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else passed++;
    total++; if ({m_addr, m_wdata, m_byteen} !== 68'h0)
      $display("FAIL reset_m_bus got=%h/%h/%b exp=0", m_addr, m_wdata, m_byteen); else passed++;
    total++; if (err !== 1'b0 || err_addr !== 32'h0)
      $display("FAIL reset_err got=%b/%h exp=0/0", err, err_addr); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else passed++;
  endtask

  task automatic test_sb_sweep();
    logic [3:0] exp_be [4];
    exp_be[0] = 4'b0001; exp_be[1] = 4'b0010; exp_be[2] = 4'b0100; exp_be[3] = 4'b1000;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h0000_00A5, 2'b10);
      tick();
      total++;
      if (m_valid !== 1'b1 || m_addr !== 32'h100 || m_wdata !== 32'hA5A5A5A5 ||
          m_byteen !== exp_be[i] || pending !== 2'd1)
        $display("FAIL sb_sweep[%0d] got v=%b a=%h d=%h be=%b p=%0d exp v=1 a=00000100 d=a5a5a5a5 be=%b p=1",
                 i, m_valid, m_addr, m_wdata, m_byteen, pending, exp_be[i]);
      else passed++;
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    total++; if (pending !== 2'd0 || m_valid !== 1'b0 || m_addr !== 32'h0)
      $display("FAIL sb_drain got p=%0d v=%b a=%h exp p=0 v=0 a=0", pending, m_valid, m_addr); else passed++;
  endtask

  task automatic test_sh_sw();
    m_ready = 1'b1;
    drive(1'b1, 32'h1002, 32'h1234BEEF, 2'b01);
    tick();
    total++; if (m_addr !== 32'h1000 || m_wdata !== 32'hBEEFBEEF || m_byteen !== 4'b1100)
      $display("FAIL sh_hi got a=%h d=%h be=%b exp a=00001000 d=beefbeef be=1100", m_addr, m_wdata, m_byteen);
    else passed++;
    drive(1'b1, 32'h2000, 32'hDEADBEEF, 2'b00);
    tick();
    total++; if (m_addr !== 32'h2000 || m_wdata !== 32'hDEADBEEF || m_byteen !== 4'b1111)
      $display("FAIL sw got a=%h d=%h be=%b exp a=00002000 d=deadbeef be=1111", m_addr, m_wdata, m_byteen);
    else passed++;
    drive(1'b1, 32'h3000, 32'h9999CAFE, 2'b01);
    tick();
    total++; if (m_addr !== 32'h3000 || m_wdata !== 32'hCAFECAFE || m_byteen !== 4'b0011)
      $display("FAIL sh_lo got a=%h d=%h be=%b exp a=00003000 d=cafecafe be=0011", m_addr, m_wdata, m_byteen);
    else passed++;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    total++; if (pending !== 2'd0) $display("FAIL sh_sw_drain got p=%0d exp=0", pending); else passed++;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    drive(1'b1, 32'h4000, 32'h11111111, 2'b00);
    tick();
    total++; if (pending !== 2'd1 || req_ready !== 1'b1)
      $display("FAIL bp_first got p=%0d rdy=%b exp p=1 rdy=1", pending, req_ready); else passed++;
    drive(1'b1, 32'h4004, 32'h22222222, 2'b00);
    tick();
    total++; if (pending !== 2'd2 || req_ready !== 1'b0)
      $display("FAIL bp_full got p=%0d rdy=%b exp p=2 rdy=0", pending, req_ready); else passed++;
    drive(1'b1, 32'h4008, 32'h33333333, 2'b00);
    tick();
    total++; if (pending !== 2'd2 || m_addr !== 32'h4000 || m_wdata !== 32'h11111111 || m_byteen !== 4'b1111)
      $display("FAIL bp_hold got p=%0d a=%h d=%h be=%b exp p=2 a=00004000 d=11111111 be=1111",
               pending, m_addr, m_wdata, m_byteen);
    else passed++;
    m_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0)
      $display("FAIL bp_no_ready_through got rdy=%b exp=0", req_ready); else passed++;
    tick();
    total++; if (pending !== 2'd1 || m_addr !== 32'h4004 || m_wdata !== 32'h22222222)
      $display("FAIL bp_pop1 got p=%0d a=%h d=%h exp p=1 a=00004004 d=22222222", pending, m_addr, m_wdata);
    else passed++;
    tick();
    total++; if (pending !== 2'd1 || m_addr !== 32'h4008 || m_wdata !== 32'h33333333)
      $display("FAIL bp_pop2 got p=%0d a=%h d=%h exp p=1 a=00004008 d=33333333", pending, m_addr, m_wdata);
    else passed++;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    total++; if (pending !== 2'd0 || m_valid !== 1'b0)
      $display("FAIL bp_empty got p=%0d v=%b exp p=0 v=0", pending, m_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    drive(1'b1, 32'h5000, 32'h000000AA, 2'b10);
    tick();
    m_ready = 1'b1;
    drive(1'b1, 32'h5006, 32'h0000BBCC, 2'b01);
    tick();
    total++; if (pending !== 2'd1 || m_addr !== 32'h5004 || m_wdata !== 32'hBBCCBBCC || m_byteen !== 4'b1100)
      $display("FAIL b2b got p=%0d a=%h d=%h be=%b exp p=1 a=00005004 d=bbccbbcc be=1100",
               pending, m_addr, m_wdata, m_byteen);
    else passed++;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    total++; if (pending !== 2'd0) $display("FAIL b2b_drain got p=%0d exp=0", pending); else passed++;
  endtask

  task automatic test_misaligned();
    logic [31:0] bad_addr [3];
    logic [1:0]  bad_op   [3];
    bad_addr[0] = 32'h1001; bad_op[0] = 2'b00;
    bad_addr[1] = 32'h1003; bad_op[1] = 2'b01;
    bad_addr[2] = 32'h1000; bad_op[2] = 2'b11;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad_addr[i], 32'hFFFFFFFF, bad_op[i]);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL mis_ready[%0d] got=%b exp=1", i, req_ready); else passed++;
      tick();
      total++; if (err !== 1'b1 || err_addr !== bad_addr[i] || pending !== 2'd0 || m_valid !== 1'b0)
        $display("FAIL mis[%0d] got err=%b ea=%h p=%0d v=%b exp err=1 ea=%h p=0 v=0",
                 i, err, err_addr, pending, m_valid, bad_addr[i]);
      else passed++;
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    total++; if (err !== 1'b0 || err_addr !== 32'h1000 || m_valid !== 1'b0)
      $display("FAIL mis_end got err=%b ea=%h v=%b exp err=0 ea=00001000 v=0", err, err_addr, m_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    drive(1'b1, 32'h6001, 32'h0, 2'b00);
    tick();
    drive(1'b1, 32'h7000, 32'h01010101, 2'b00);
    tick();
    drive(1'b1, 32'h7004, 32'h02020202, 2'b00);
    tick();
    total++; if (pending !== 2'd2 || err_addr !== 32'h6001)
      $display("FAIL rmid_pre got p=%0d ea=%h exp p=2 ea=00006001", pending, err_addr); else passed++;
    // Second reset cycle presents a store while ready is 1; it must be ignored.
    reset = 1'b1; m_ready = 1'b1;
    drive(1'b1, 32'h8000, 32'h000000EE, 2'b10);
    tick(); tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    total++; if (pending !== 2'd0 || m_valid !== 1'b0 || err !== 1'b0 || err_addr !== 32'h0 || req_ready !== 1'b1)
      $display("FAIL rmid_post got p=%0d v=%b err=%b ea=%h rdy=%b exp p=0 v=0 err=0 ea=0 rdy=1",
               pending, m_valid, err, err_addr, req_ready);
    else passed++;
    tick();
    total++; if (m_valid !== 1'b0 || m_addr !== 32'h0)
      $display("FAIL rmid_quiet got v=%b a=%h exp v=0 a=0", m_valid, m_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sb_sweep();
    test_sh_sw();
    test_backpressure();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
